vec_lane_rr_arbiter: RTL

//  Round-robin burst arbiter sharing one N-bit vector lane among five requesters.

---
 rtl/vec_arb_pkg.sv | 26 ++
 rtl/rr_pick5.sv | 26 ++
 rtl/vec_lane_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vec_arb_pkg.sv
// Shared types and helpers for the five-way vector lane round-robin arbiter.
// Owner select codes are 1-based so that 3'b000 can mean "no owner".
package vec_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    OWN
  } arb_state_t;

  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam int unsigned NREQ = 5;

  function automatic logic [2:0] idx2sel(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

  function automatic logic [2:0] sel2idx(input logic [2:0] sel);
    return sel - 3'd1;
  endfunction

  // Next requester index modulo NREQ; out-of-range inputs fold back to 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (idx >= 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first set req bit searching ptr+1, ptr+2, ... mod 5.
module rr_pick5
  import vec_arb_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    cand  = wrap_inc(ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

endmodule

// File: rtl/vec_lane_rr_arbiter.sv
// Round-robin burst arbiter sharing one N-bit vector lane among five requesters,
// with a single registered valid/ready output stage.
module vec_lane_rr_arbiter
  import vec_arb_pkg::*;
#(
  parameter int unsigned N         = 20,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   req,
  input  logic [4:0]   last,
  input  logic [N-1:0] ent1,
  input  logic [N-1:0] ent2,
  input  logic [N-1:0] ent3,
  input  logic [N-1:0] ent4,
  input  logic [N-1:0] ent5,
  output logic [4:0]   gnt,
  output logic [2:0]   select,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [2:0]   out_src,
  input  logic         out_ready
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  arb_state_t     state;
  logic [2:0]     ptr;
  logic [CntW-1:0] beat_cnt;

  logic [2:0]      owner;
  logic [NREQ-1:0] owner_oh;
  logic            owner_req;
  logic            slot_free;
  logic            take;
  logic            rel_burst;
  logic [N-1:0]    mux_data;
  logic            pick_valid;
  logic [2:0]      pick_idx;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner     = sel2idx(select);
  // Gate on OWN so the idle code (owner decodes to 7) never selects a bit.
  assign owner_oh  = (state == OWN) ? NREQ'(5'b00001 << owner) : '0;
  assign owner_req = |(req & owner_oh);
  assign slot_free = ~out_valid | out_ready;
  assign gnt       = owner_oh & req & {NREQ{slot_free}};
  assign take      = |gnt;

  // gnt only ever carries the owner's bit, so last & gnt is last[owner] & gnt.
  assign rel_burst = (state == OWN) &&
                     (|(last & gnt) || (take && beat_cnt == LastCnt) || !owner_req);

  always_comb begin
    case (owner)
      3'd0:    mux_data = ent1;
      3'd1:    mux_data = ent2;
      3'd2:    mux_data = ent3;
      3'd3:    mux_data = ent4;
      3'd4:    mux_data = ent5;
      default: mux_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      select    <= SEL_IDLE;
      ptr       <= 3'd4;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SEL_IDLE;
    end else begin
      if (take) begin
        out_data  <= mux_data;
        out_src   <= select;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_valid) begin
            select   <= idx2sel(pick_idx);
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (take) begin
            beat_cnt <= beat_cnt + CntW'(1);
          end
          if (rel_burst) begin
            ptr    <= owner;
            select <= SEL_IDLE;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_sel_range  : assert property (@(posedge clk) disable iff (rst) select <= 3'd5);
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
                                  out_valid && !out_ready |=> out_valid && $stable(out_data)
                                                              && $stable(out_src));

endmodule
